// File: rtl/cpu_axi_bridge.sv
// cpu_axi_bridge: SRAM-style inst/data ports to a single AXI master.
// One transaction in flight; data port wins arbitration over inst.
module cpu_axi_bridge #(
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_sram_req,
    input  logic [31:0] inst_sram_addr,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    input  logic [3:0]  data_sram_wstrb,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,

    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,

    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,

    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {
        IDLE,
        RADDR,
        RDATA,
        WREQ,
        WRESP
    } state_t;

    state_t      state;

    logic        req_data;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;

    logic        grant_data;
    logic        grant_inst;
    logic        aw_done;
    logic        w_done;

    // Response fields and IDs are not used: no error signalling.
    logic        unused_resp;
    assign unused_resp = ^{rid, rresp, bresp};

    // Arbitration is combinational so addr_ok lands in the request cycle.
    assign grant_data = ~reset & (state == IDLE) & data_sram_req;
    assign grant_inst = ~reset & (state == IDLE) & inst_sram_req
                      & ~data_sram_req;

    assign data_sram_addr_ok = grant_data;
    assign inst_sram_addr_ok = grant_inst;

    // A channel is finished once it was handshaken now or earlier.
    assign aw_done = ~awvalid | awready;
    assign w_done  = ~wvalid | wready;

    // Fixed single-beat incrementing burst attributes.
    assign arlen   = 8'd0;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign awlen   = 8'd0;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign wlast   = 1'b1;

    // Channel payloads come straight from the captured request.
    assign arid   = req_data ? DATA_ID : INST_ID;
    assign araddr = req_addr;
    assign arsize = {1'b0, req_size};
    assign awid   = DATA_ID;
    assign awaddr = req_addr;
    assign awsize = {1'b0, req_size};
    assign wid    = DATA_ID;
    assign wdata  = req_wdata;
    assign wstrb  = req_wstrb;

    // Capture the granted request so the AXI side stays stable.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_data  <= 1'b0;
            req_addr  <= 32'd0;
            req_size  <= 2'd0;
            req_wdata <= 32'd0;
            req_wstrb <= 4'd0;
        end else if (grant_data) begin
            req_data  <= 1'b1;
            req_addr  <= data_sram_addr;
            req_size  <= data_sram_size;
            req_wdata <= data_sram_wdata;
            req_wstrb <= data_sram_wstrb;
        end else if (grant_inst) begin
            req_data  <= 1'b0;
            req_addr  <= inst_sram_addr;
            req_size  <= 2'd2;
            req_wdata <= 32'd0;
            req_wstrb <= 4'd0;
        end
    end

    // Transaction FSM with registered AXI valids/readies and data_ok.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            arvalid           <= 1'b0;
            rready            <= 1'b0;
            awvalid           <= 1'b0;
            wvalid            <= 1'b0;
            bready            <= 1'b0;
            inst_sram_data_ok <= 1'b0;
            data_sram_data_ok <= 1'b0;
            inst_sram_rdata   <= 32'd0;
            data_sram_rdata   <= 32'd0;
        end else begin
            inst_sram_data_ok <= 1'b0;
            data_sram_data_ok <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant_data && data_sram_wr) begin
                        awvalid <= 1'b1;
                        wvalid  <= 1'b1;
                        state   <= WREQ;
                    end else if (grant_data || grant_inst) begin
                        arvalid <= 1'b1;
                        state   <= RADDR;
                    end
                end
                RADDR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= RDATA;
                    end
                end
                RDATA: begin
                    if (rvalid) begin
                        rready <= 1'b0;
                        state  <= IDLE;
                        if (req_data) begin
                            data_sram_data_ok <= 1'b1;
                            data_sram_rdata   <= rdata;
                        end else begin
                            inst_sram_data_ok <= 1'b1;
                            inst_sram_rdata   <= rdata;
                        end
                    end
                end
                WREQ: begin
                    if (awready) begin
                        awvalid <= 1'b0;
                    end
                    if (wready) begin
                        wvalid <= 1'b0;
                    end
                    if (aw_done && w_done) begin
                        bready <= 1'b1;
                        state  <= WRESP;
                    end
                end
                WRESP: begin
                    if (bvalid) begin
                        bready            <= 1'b0;
                        data_sram_data_ok <= 1'b1;
                        state             <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// tb_cpu_axi_bridge: directed scenarios plus randomized traffic
// checked against a transaction-level model of the bridge.
module tb_cpu_axi_bridge;

    logic        clk = 1'b0;
    logic        reset;

    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [3:0]  data_sram_wstrb;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    always #5 clk = ~clk;

    cpu_axi_bridge dut (
        .clk(clk), .reset(reset),
        .inst_sram_req(inst_sram_req), .inst_sram_addr(inst_sram_addr),
        .inst_sram_addr_ok(inst_sram_addr_ok),
        .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
        .data_sram_wdata(data_sram_wdata),
        .data_sram_wstrb(data_sram_wstrb),
        .data_sram_addr_ok(data_sram_addr_ok),
        .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache),
        .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rvalid(rvalid),
        .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awlock(awlock), .awcache(awcache),
        .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        inst_sram_req   = 1'b0;
        inst_sram_addr  = 32'd0;
        data_sram_req   = 1'b0;
        data_sram_wr    = 1'b0;
        data_sram_size  = 2'd0;
        data_sram_addr  = 32'd0;
        data_sram_wdata = 32'd0;
        data_sram_wstrb = 4'd0;
        arready = 1'b0;
        rid     = 4'd0;
        rdata   = 32'd0;
        rresp   = 2'd0;
        rvalid  = 1'b0;
        awready = 1'b0;
        wready  = 1'b0;
        bresp   = 2'd0;
        bvalid  = 1'b0;
    endtask

    // Instruction fetch with ready slave: addr_ok N, arvalid N+1, data_ok N+3.
    task automatic do_inst_read(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        inst_sram_req  = 1'b1;
        inst_sram_addr = a;
        arready        = 1'b1;
        #1;
        check("ird_addr_ok", inst_sram_addr_ok, 1);
        check("ird_daddr_ok", data_sram_addr_ok, 0);
        @(negedge clk);
        inst_sram_req = 1'b0;
        #1;
        check("ird_arvalid", arvalid, 1);
        check("ird_araddr", araddr, a);
        check("ird_arid", arid, 0);
        check("ird_arsize", arsize, 2);
        @(negedge clk);
        arready = 1'b0;
        rvalid  = 1'b1;
        rdata   = d;
        #1;
        check("ird_rready", rready, 1);
        check("ird_early_ok", inst_sram_data_ok, 0);
        @(negedge clk);
        rvalid = 1'b0;
        rdata  = 32'd0;
        #1;
        check("ird_data_ok", inst_sram_data_ok, 1);
        check("ird_rdata", inst_sram_rdata, d);
        @(negedge clk);
        #1;
        check("ird_ok_pulse", inst_sram_data_ok, 0);
    endtask

    // Reference memory: unwritten words have a hashed default value.
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] word(input logic [31:0] a);
        logic [31:0] k;
        k = a & ~32'h3;
        if (mem.exists(k)) return mem[k];
        return (k * 32'h9e3779b1) ^ 32'h13579bdf;
    endfunction

    // Random-phase requester and outstanding-transaction state.
    logic        i_pend, d_pend, d_wr;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [1:0]  d_size;
    logic [3:0]  d_wstrb;
    logic [1:0]  off;
    logic        o_valid, o_data, o_wr, o_fin;
    logic        ar_done, aw_done, w_done;
    logic [31:0] o_addr, o_wdata, o_exp, wv;
    logic [1:0]  o_size;
    logic [3:0]  o_wstrb;
    logic        free, g_data, g_inst, e_act;

    initial begin
        idle_inputs();
        reset         = 1'b1;
        inst_sram_req = 1'b1;
        data_sram_req = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_iaddr_ok", inst_sram_addr_ok, 0);
        check("rst_daddr_ok", data_sram_addr_ok, 0);
        check("rst_arvalid", arvalid, 0);
        check("rst_awvalid", awvalid, 0);
        check("rst_wvalid", wvalid, 0);
        check("rst_rready", rready, 0);
        check("rst_bready", bready, 0);
        check("rst_idata_ok", inst_sram_data_ok, 0);
        check("rst_ddata_ok", data_sram_data_ok, 0);
        check("rst_irdata", inst_sram_rdata, 0);
        check("rst_drdata", data_sram_rdata, 0);
        check("const_arburst", arburst, 1);
        check("const_awlen", awlen, 0);
        check("const_wlast", wlast, 1);
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();

        // Basic instruction fetch.
        do_inst_read(32'h1c000000, 32'h02800c0c);

        // Simultaneous requests: data first, inst in data_ok cycle.
        @(negedge clk);
        inst_sram_req  = 1'b1;
        inst_sram_addr = 32'h1c000004;
        data_sram_req  = 1'b1;
        data_sram_wr   = 1'b0;
        data_sram_size = 2'd2;
        data_sram_addr = 32'h00000100;
        #1;
        check("pri_daddr_ok", data_sram_addr_ok, 1);
        check("pri_iaddr_ok", inst_sram_addr_ok, 0);
        @(negedge clk);
        data_sram_req = 1'b0;
        arready       = 1'b1;
        #1;
        check("pri_arvalid", arvalid, 1);
        check("pri_arid", arid, 1);
        check("pri_araddr", araddr, 32'h100);
        check("pri_iwait1", inst_sram_addr_ok, 0);
        @(negedge clk);
        arready = 1'b0;
        rvalid  = 1'b1;
        rdata   = 32'h11223344;
        #1;
        check("pri_iwait2", inst_sram_addr_ok, 0);
        @(negedge clk);
        rvalid = 1'b0;
        #1;
        check("pri_ddata_ok", data_sram_data_ok, 1);
        check("pri_drdata", data_sram_rdata, 32'h11223344);
        check("pri_igrant", inst_sram_addr_ok, 1);
        @(negedge clk);
        inst_sram_req = 1'b0;
        arready       = 1'b1;
        #1;
        check("pri_iarid", arid, 0);
        check("pri_iaraddr", araddr, 32'h1c000004);
        @(negedge clk);
        arready = 1'b0;
        rvalid  = 1'b1;
        rdata   = 32'h55667788;
        @(negedge clk);
        rvalid = 1'b0;
        #1;
        check("pri_idata_ok", inst_sram_data_ok, 1);
        check("pri_irdata", inst_sram_rdata, 32'h55667788);

        // Byte write, awready two cycles ahead of wready.
        @(negedge clk);
        data_sram_req   = 1'b1;
        data_sram_wr    = 1'b1;
        data_sram_size  = 2'd0;
        data_sram_addr  = 32'h8;
        data_sram_wdata = 32'h000000ab;
        data_sram_wstrb = 4'b0001;
        #1;
        check("wr_addr_ok", data_sram_addr_ok, 1);
        @(negedge clk);
        data_sram_req = 1'b0;
        data_sram_wr  = 1'b0;
        awready       = 1'b1;
        #1;
        check("wr_awvalid", awvalid, 1);
        check("wr_wvalid", wvalid, 1);
        check("wr_awaddr", awaddr, 32'h8);
        check("wr_awsize", awsize, 0);
        check("wr_awid", awid, 1);
        check("wr_wstrb", wstrb, 4'b0001);
        check("wr_wdata", wdata, 32'h000000ab);
        @(negedge clk);
        awready = 1'b0;
        #1;
        check("wr_aw_drop", awvalid, 0);
        check("wr_w_hold1", wvalid, 1);
        check("wr_no_bready", bready, 0);
        @(negedge clk);
        wready = 1'b1;
        #1;
        check("wr_w_hold2", wvalid, 1);
        @(negedge clk);
        wready = 1'b0;
        bvalid = 1'b1;
        #1;
        check("wr_w_drop", wvalid, 0);
        check("wr_bready", bready, 1);
        check("wr_early_ok", data_sram_data_ok, 0);
        @(negedge clk);
        bvalid = 1'b0;
        #1;
        check("wr_data_ok", data_sram_data_ok, 1);
        check("wr_bready_off", bready, 0);

        // arready stalled for five cycles with inst_req held.
        @(negedge clk);
        inst_sram_req  = 1'b1;
        inst_sram_addr = 32'h1c000100;
        #1;
        check("stl_addr_ok", inst_sram_addr_ok, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("stl_arvalid", arvalid, 1);
            check("stl_araddr", araddr, 32'h1c000100);
            check("stl_no_addr_ok", inst_sram_addr_ok, 0);
        end
        @(negedge clk);
        inst_sram_req = 1'b0;
        arready       = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        rvalid  = 1'b1;
        rdata   = 32'hcafef00d;
        @(negedge clk);
        rvalid = 1'b0;
        #1;
        check("stl_data_ok", inst_sram_data_ok, 1);
        check("stl_rdata", inst_sram_rdata, 32'hcafef00d);

        // Reset while waiting for read data abandons the fetch.
        @(negedge clk);
        inst_sram_req  = 1'b1;
        inst_sram_addr = 32'h1c000200;
        arready        = 1'b1;
        @(negedge clk);
        inst_sram_req = 1'b0;
        @(negedge clk);
        arready = 1'b0;
        #1;
        check("abt_rready", rready, 1);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("abt_rready_rst", rready, 0);
        reset = 1'b0;
        @(negedge clk);
        rvalid = 1'b1;
        rdata  = 32'hdeadbeef;
        #1;
        check("abt_rready_idle", rready, 0);
        @(negedge clk);
        rvalid = 1'b0;
        #1;
        check("abt_no_ok1", inst_sram_data_ok, 0);
        @(negedge clk);
        #1;
        check("abt_no_ok2", inst_sram_data_ok, 0);
        do_inst_read(32'h1c000204, 32'h0badf00d);

        // Randomized traffic against the transaction model.
        idle_inputs();
        i_pend  = 1'b0;
        d_pend  = 1'b0;
        o_valid = 1'b0;
        o_fin   = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (!i_pend && $urandom_range(0, 2) == 0) begin
                i_pend = 1'b1;
                i_addr = 32'h1c000000 | (32'($urandom_range(0, 63)) << 2);
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend  = 1'b1;
                d_wr    = 1'($urandom_range(0, 1));
                d_size  = 2'($urandom_range(0, 2));
                d_wdata = $urandom;
                off     = 2'($urandom_range(0, 3));
                if (d_size == 2'd1) off = {off[1], 1'b0};
                if (d_size == 2'd2) off = 2'd0;
                d_addr  = (32'($urandom_range(0, 63)) << 2) | 32'(off);
                d_wstrb = (d_size == 2'd0) ? (4'b0001 << off) :
                          (d_size == 2'd1) ? (4'b0011 << off) : 4'b1111;
            end
            inst_sram_req   = i_pend;
            inst_sram_addr  = i_addr;
            data_sram_req   = d_pend;
            data_sram_wr    = d_wr;
            data_sram_size  = d_size;
            data_sram_addr  = d_addr;
            data_sram_wdata = d_wdata;
            data_sram_wstrb = d_wstrb;
            arready = 1'($urandom_range(0, 1));
            awready = 1'($urandom_range(0, 1));
            wready  = 1'($urandom_range(0, 1));
            rvalid  = 1'b0;
            bvalid  = 1'b0;
            if (o_valid && !o_fin && !o_wr && ar_done)
                rvalid = 1'($urandom_range(0, 1));
            if (o_valid && !o_fin && o_wr && aw_done && w_done)
                bvalid = 1'($urandom_range(0, 1));
            rdata = rvalid ? word(o_addr) : $urandom;
            #1;

            free   = !o_valid || o_fin;
            g_data = free && d_pend;
            g_inst = free && i_pend && !d_pend;
            check("r_daddr_ok", data_sram_addr_ok, g_data);
            check("r_iaddr_ok", inst_sram_addr_ok, g_inst);
            check("r_idata_ok", inst_sram_data_ok, o_valid && o_fin && !o_data);
            check("r_ddata_ok", data_sram_data_ok, o_valid && o_fin && o_data);
            if (o_valid && o_fin && !o_wr) begin
                check("r_rdata", o_data ? data_sram_rdata : inst_sram_rdata,
                      o_exp);
            end
            e_act = o_valid && !o_fin;
            check("r_arvalid", arvalid, e_act && !o_wr && !ar_done);
            check("r_rready", rready, e_act && !o_wr && ar_done);
            check("r_awvalid", awvalid, e_act && o_wr && !aw_done);
            check("r_wvalid", wvalid, e_act && o_wr && !w_done);
            check("r_bready", bready, e_act && o_wr && aw_done && w_done);
            if (e_act && !o_wr && !ar_done) begin
                check("r_araddr", araddr, o_addr);
                check("r_arsize", arsize, {1'b0, o_size});
                check("r_arid", arid, o_data ? 4'd1 : 4'd0);
            end
            if (e_act && o_wr && !aw_done) begin
                check("r_awaddr", awaddr, o_addr);
                check("r_awsize", awsize, {1'b0, o_size});
            end
            if (e_act && o_wr && !w_done) begin
                check("r_wdata", wdata, o_wdata);
                check("r_wstrb", wstrb, o_wstrb);
            end

            if (o_valid && o_fin) begin
                o_valid = 1'b0;
            end else if (o_valid && !o_wr) begin
                if (ar_done && rvalid) o_fin = 1'b1;
                if (!ar_done && arready) ar_done = 1'b1;
            end else if (o_valid) begin
                if (aw_done && w_done && bvalid) o_fin = 1'b1;
                if (!aw_done && awready) aw_done = 1'b1;
                if (!w_done && wready) w_done = 1'b1;
            end
            if (g_data || g_inst) begin
                o_valid = 1'b1;
                o_fin   = 1'b0;
                ar_done = 1'b0;
                aw_done = 1'b0;
                w_done  = 1'b0;
                o_data  = g_data;
                o_wr    = g_data && d_wr;
                o_addr  = g_data ? d_addr : i_addr;
                o_size  = g_data ? d_size : 2'd2;
                o_wdata = d_wdata;
                o_wstrb = d_wstrb;
                if (o_wr) begin
                    wv = word(o_addr);
                    for (int b = 0; b < 4; b++)
                        if (o_wstrb[b]) wv[b*8 +: 8] = o_wdata[b*8 +: 8];
                    mem[o_addr & ~32'h3] = wv;
                end else begin
                    o_exp = word(o_addr);
                end
                if (g_data) d_pend = 1'b0;
                else i_pend = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
